// File: rtl/read_data_collector_if.sv
// AXI4 read-data channel plus AXI-Stream output, bundled for the collector.
// slave  : the collector's view (consumes R beats, produces the stream)
// master : the surrounding fabric's view (drives R beats, sinks the stream)
interface read_data_collector_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tlast;
  logic                  m_tvalid;
  logic                  m_tready;

  modport master (
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  m_tdata, m_tlast, m_tvalid,
    output m_tready
  );

  modport slave (
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output m_tdata, m_tlast, m_tvalid,
    input  m_tready
  );
endinterface

// File: rtl/read_data_collector.sv
// Collects AXI4 R beats for one job, forwards the payload beats to an
// AXI-Stream port through a 2-entry FIFO and drops burst padding.
//
// state | meaning
// IDLE  | no job, done=1, waiting for start
// RECV  | accepting R beats until the last beat of the last burst
// FLUSH | all R beats taken, draining the output FIFO
module read_data_collector #(
  parameter int DATA_WIDTH               = 64,
  parameter int ID_WIDTH                 = 8,
  parameter int ADDR_WIDTH               = 32,
  parameter int AxLEN_BEATS_PER_TRANSFER = 15
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] dataSizeInBeats,
  output logic                  error,
  output logic                  protocolError,
  read_data_collector_if.slave  bus
);

  localparam int BEATS = AxLEN_BEATS_PER_TRANSFER + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] payload;
  logic [ADDR_WIDTH:0]   rcnt;
  // Position inside the current burst; replaces rcnt % BEATS.
  logic [BW-1:0]         bpos;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wptr;
  logic                  rptr;
  logic [1:0]            count;

  logic [ID_WIDTH-1:0]   unused_rid;
  assign unused_rid = bus.rid;

  logic                  accept;
  logic                  burst_end;
  logic [ADDR_WIDTH:0]   payload_x;
  logic                  forward;
  logic                  is_last;
  logic                  job_end;
  logic                  pop;

  assign payload_x = {1'b0, payload};
  assign accept    = bus.rvalid && bus.rready;
  assign burst_end = (bpos == BW'(BEATS - 1));
  assign forward   = accept && (rcnt < payload_x);
  assign is_last   = (rcnt == payload_x - 1'b1);
  // The final beat of the job is the first burst end that covers the
  // payload; payload=0 still ends on the first burst end (one padding burst).
  // This equals rcnt == total-1 without needing a divider.
  assign job_end   = accept && burst_end && ((rcnt + 1'b1) >= payload_x);
  assign pop       = bus.m_tvalid && bus.m_tready;

  // rready depends only on registered state/occupancy: no m_tready->rready path.
  assign bus.rready   = (state == RECV) && (count != 2'd2);
  assign bus.m_tvalid = (count != 2'd0);
  assign bus.m_tdata  = fifo_data[rptr];
  assign bus.m_tlast  = fifo_last[rptr];
  assign done         = (state == IDLE);

  // Job FSM, beat counters and sticky status flags.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state         <= IDLE;
      payload       <= '0;
      rcnt          <= '0;
      bpos          <= '0;
      error         <= 1'b0;
      protocolError <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            payload       <= dataSizeInBeats;
            rcnt          <= '0;
            bpos          <= '0;
            error         <= 1'b0;
            protocolError <= 1'b0;
            state         <= RECV;
          end
        end
        RECV: begin
          if (accept) begin
            rcnt <= rcnt + 1'b1;
            bpos <= burst_end ? '0 : bpos + 1'b1;
            if (bus.rresp != 2'b00) error <= 1'b1;
            if (bus.rlast != burst_end) protocolError <= 1'b1;
            if (job_end) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (count == 2'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; buffered beats are discarded on reset.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (forward) wptr <= ~wptr;
      if (pop) rptr <= ~rptr;
      case ({forward, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge aclk) begin
    if (forward) begin
      fifo_data[wptr] <= bus.rdata;
      fifo_last[wptr] <= is_last;
    end
  end

endmodule

// File: tb/tb_read_data_collector.sv
// Directed bench for read_data_collector (BEATS=16).
module tb_read_data_collector;

  localparam int DW = 64;
  localparam int IW = 8;
  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] size = '0;
  logic          done;
  logic          error;
  logic          perr;

  read_data_collector_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  read_data_collector #(
    .DATA_WIDTH(DW),
    .ID_WIDTH(IW),
    .ADDR_WIDTH(AW),
    .AxLEN_BEATS_PER_TRANSFER(15)
  ) dut (
    .aclk(aclk),
    .resetn(resetn),
    .start(start),
    .done(done),
    .dataSizeInBeats(size),
    .error(error),
    .protocolError(perr),
    .bus(bus.slave)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int passed = 0;

  // Stream monitor state (written only by the monitor, cleared by main when idle)
  int          cyc = 0;
  int          bp_mode = 0;
  logic [63:0] q_data[$];
  bit          q_last[$];
  bit          rready_dropped = 0;
  bit          tvalid_seen = 0;
  int          hold_viol = 0;
  int          last_pop_cyc = 0;
  int          done_rise_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: sets m_tready each cycle and records handshakes that complete
  // on the following rising edge.
  initial begin
    logic        prev_done;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic        prev_last;
    prev_done  = 1'b1;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    bus.m_tready = 1'b1;
    forever begin
      @(negedge aclk);
      cyc++;
      if (resetn && prev_stall &&
          (!bus.m_tvalid || bus.m_tdata !== prev_data || bus.m_tlast !== prev_last))
        hold_viol++;
      case (bp_mode)
        0:       bus.m_tready = 1'b1;
        1:       bus.m_tready = (cyc % 2 == 0);
        default: bus.m_tready = 1'b0;
      endcase
      if (bus.m_tvalid) tvalid_seen = 1;
      if (resetn && bus.m_tvalid && bus.m_tready) begin
        q_data.push_back(bus.m_tdata);
        q_last.push_back(bus.m_tlast);
        last_pop_cyc = cyc;
      end
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_last  = bus.m_tlast;
      if (bus.rvalid && !bus.rready && !done) rready_dropped = 1;
      if (done && !prev_done) done_rise_cyc = cyc;
      prev_done = done;
    end
  end

  task automatic begin_job(input int n);
    q_data.delete();
    q_last.delete();
    tvalid_seen = 0;
    rready_dropped = 0;
    @(negedge aclk);
    size  = n;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  // Offers n R beats; a beat counts as accepted when rready is high while offered.
  task automatic send(input int n, input logic [63:0] base, input int err_idx,
                      input int badlast_idx, output int acc);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 400) begin
      @(negedge aclk);
      bus.rvalid = 1'b1;
      bus.rdata  = base + 64'(i);
      bus.rid    = 8'(i) ^ 8'h5a;
      bus.rresp  = (i == err_idx) ? 2'b10 : 2'b00;
      bus.rlast  = ((i % 16) == 15) || (i == badlast_idx);
      if (bus.rready) i++;
      guard++;
    end
    @(negedge aclk);
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    acc = i;
  endtask

  task automatic wait_done(input string tag);
    int guard;
    guard = 0;
    while (!done && guard < 300) begin
      @(negedge aclk);
      guard++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic check_stream(input string tag, input int n, input logic [63:0] base);
    check({tag, "_count"}, q_data.size(), n);
    for (int i = 0; i < n && i < q_data.size(); i++) begin
      check({tag, "_data"}, q_data[i], base + 64'(i));
      check({tag, "_last"}, q_last[i], (i == n - 1));
    end
  endtask

  initial begin
    int acc;
    bus.rvalid = 1'b0;
    bus.rdata  = '0;
    bus.rid    = '0;
    bus.rresp  = 2'b00;
    bus.rlast  = 1'b0;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_done", done, 1'b1);
    check("rst_rready", bus.rready, 1'b0);
    check("rst_tvalid", bus.m_tvalid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_perr", perr, 1'b0);
    resetn = 1'b1;
    @(negedge aclk);

    // payload=16, no backpressure
    bp_mode = 0;
    begin_job(16);
    check("p16_busy", done, 1'b0);
    send(16, 64'h1000_0000_0000_0000, -1, -1, acc);
    check("p16_acc", acc, 16);
    wait_done("p16_done");
    check_stream("p16", 16, 64'h1000_0000_0000_0000);
    check("p16_done_lat", done_rise_cyc - last_pop_cyc, 2);
    check("p16_error", error, 1'b0);
    check("p16_perr", perr, 1'b0);

    // payload=17: two bursts, 15 padding beats dropped
    begin_job(17);
    send(32, 64'h2000_0000_0000_0000, -1, -1, acc);
    check("p17_acc", acc, 32);
    wait_done("p17_done");
    check_stream("p17", 17, 64'h2000_0000_0000_0000);
    check("p17_perr", perr, 1'b0);

    // payload=0: one padding burst, no stream output
    begin_job(0);
    send(16, 64'h3000_0000_0000_0000, -1, -1, acc);
    check("p0_acc", acc, 16);
    wait_done("p0_done");
    check("p0_tvalid", tvalid_seen, 1'b0);
    check("p0_count", q_data.size(), 0);

    // Backpressure: m_tready toggles, payload=20
    bp_mode = 1;
    begin_job(20);
    send(32, 64'h4000_0000_0000_0000, -1, -1, acc);
    check("bp_acc", acc, 32);
    wait_done("bp_done");
    check_stream("bp", 20, 64'h4000_0000_0000_0000);
    check("bp_rready_drop", rready_dropped, 1'b1);
    check("bp_hold", hold_viol, 0);
    bp_mode = 0;

    // rresp=2 on beat 5, stray rlast on beat 3
    begin_job(16);
    send(16, 64'h5000_0000_0000_0000, 5, 3, acc);
    check("err_acc", acc, 16);
    wait_done("err_done");
    check_stream("err", 16, 64'h5000_0000_0000_0000);
    check("err_error", error, 1'b1);
    check("err_perr", perr, 1'b1);
    repeat (5) @(negedge aclk);
    check("err_error_sticky", error, 1'b1);
    check("err_perr_sticky", perr, 1'b1);

    // Next start clears the sticky flags
    begin_job(16);
    check("clr_error", error, 1'b0);
    check("clr_perr", perr, 1'b0);
    send(16, 64'h6000_0000_0000_0000, -1, -1, acc);
    wait_done("clr_done");
    check_stream("clr", 16, 64'h6000_0000_0000_0000);
    check("clr_error_end", error, 1'b0);

    // Reset mid-job after 7 beats, then a fresh payload=4 job
    begin_job(16);
    send(7, 64'h7000_0000_0000_0000, -1, -1, acc);
    check("mid_acc", acc, 7);
    resetn = 1'b0;
    @(negedge aclk);
    check("mid_done", done, 1'b1);
    check("mid_tvalid", bus.m_tvalid, 1'b0);
    check("mid_rready", bus.rready, 1'b0);
    resetn = 1'b1;
    begin_job(4);
    send(16, 64'h8000_0000_0000_0000, -1, -1, acc);
    check("p4_acc", acc, 16);
    wait_done("p4_done");
    check_stream("p4", 4, 64'h8000_0000_0000_0000);
    check("p4_hold", hold_viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/read_data_collector.md
READ_DATA_COLLECTOR -- requirements
Module: read_data_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the R-channel and stream data width in bits.
REQ-002 SHALL have parameter ID_WIDTH, default 8, meaning the rid width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, meaning the dataSizeInBeats width.
REQ-004 SHALL have parameter AxLEN_BEATS_PER_TRANSFER, default 15, meaning the beats per burst minus one, matching the address generator.
REQ-005 SHALL have port aclk, input, 1 bit, meaning the only clock; all logic on rising edge.
REQ-006 SHALL have port resetn, input, 1 bit, meaning a synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit, meaning a job request, accepted only when done=1.
REQ-008 SHALL have port done, output, 1 bit, meaning the block is idle or the job is complete.
REQ-009 SHALL have port dataSizeInBeats, input, ADDR_WIDTH bits, meaning the payload beats, sampled at start.
REQ-010 SHALL have port error, output, 1 bit, meaning a sticky flag for any rresp!=0 in the job.
REQ-011 SHALL have port protocolError, output, 1 bit, meaning a sticky flag for an rlast position mismatch.
REQ-012 SHALL have rid (input, ID_WIDTH), rdata (input, DATA_WIDTH), rresp (input, 2), rlast (input, 1), rvalid (input, 1) and rready (output, 1), forming the AXI4 read data channel.
REQ-013 SHALL have m_tdata (output, DATA_WIDTH), m_tlast (output, 1), m_tvalid (output, 1) and m_tready (input, 1), forming the AXI-Stream output.

Function
REQ-014 SHALL implement the states IDLE, RECV and FLUSH.
  - IDLE: done=1.
  - RECV and FLUSH: done=0.
REQ-015 SHALL, on start && done, perform the following, moving IDLE->RECV:
  - clear error and protocolError;
  - latch payload=dataSizeInBeats;
  - compute total = max(1, ceil(payload/BEATS)) * BEATS, where BEATS=AxLEN_BEATS_PER_TRANSFER+1.
REQ-016 SHALL ignore start when done=0.
REQ-017 SHALL count an R beat as accepted on rvalid && rready; rcnt (ADDR_WIDTH+1 bits) increments per beat.
REQ-018 SHALL forward accepted beats with rcnt < payload into the output buffer.
REQ-019 SHALL drop beats with rcnt >= payload (burst padding) while still accepting them.
REQ-020 SHALL set m_tlast=1 exactly on the forwarded beat with rcnt == payload-1.
REQ-021 SHALL set protocolError if rlast differs from ((rcnt % BEATS) == BEATS-1) on any accepted beat.
REQ-022 SHALL set error if rresp != 0 on any accepted beat, including dropped beats.
REQ-023 SHALL ignore rid.
REQ-024 SHALL buffer output in a 2-entry skid FIFO, with the following rules:
  - rready = (state==RECV) && (FIFO not full);
  - m_tvalid = FIFO not empty;
  - m_tdata/m_tlast driven from the FIFO head.
REQ-025 SHALL allow simultaneous push and pop on a full FIFO only if m_tready=1; rready is computed from registered occupancy, so there is no combinational path m_tready->rready.
REQ-026 SHALL produce the first beat on m_tvalid 1 cycle after R acceptance, and sustain 1 beat/cycle when m_tready=1.
REQ-027 SHALL move RECV->FLUSH on the accepting edge of beat rcnt == total-1.
REQ-028 SHALL move FLUSH->IDLE when the FIFO is empty; done rises the same edge.
REQ-029 SHALL produce no m_tvalid for payload=0; the job still consumes one padding burst.
REQ-030 SHALL hold m_tdata/m_tlast stable while m_tvalid && !m_tready.

Reset
REQ-031 SHALL, when resetn=0 at a clock edge, force the following, regardless of any in-flight job:
  - state=IDLE;
  - done=1;
  - rready=0;
  - m_tvalid=0;
  - FIFO empty;
  - rcnt=0;
  - error=0;
  - protocolError=0.
REQ-032 SHALL discard buffered beats on reset mid-job; the first start after reset begins a fresh job.
REQ-033 SHALL leave m_tdata undefined/don't-care at reset.

Verification
REQ-034 SHALL be verified with payload=16, BEATS=16, m_tready=1: 16 beats out, m_tlast on beat 15, done=1 one edge after FIFO drains, no errors.
REQ-035 SHALL be verified with payload=17: 32 R beats accepted, 17 forwarded, m_tlast on beat 16, beats 17..31 dropped.
REQ-036 SHALL be verified with payload=0: 16 R beats accepted, m_tvalid never high, done returns.
REQ-037 SHALL be verified with backpressure (m_tready toggling 1010...): data order intact, rready drops when FIFO holds 2, no beat lost or duplicated.
REQ-038 SHALL be verified with rresp=2 on beat 5 and rlast on beat 3 (BEATS=16): error=1 and protocolError=1 persist until next start; the stream is otherwise unaffected.
REQ-039 SHALL be verified with resetn=0 mid-job after 7 beats: next cycle done=1, m_tvalid=0; a new start with payload=4 yields exactly 4 beats, m_tlast on beat 3.
